// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl
// Hardwired Moore micro-sequencer for the accumulator CPU datapath.
// It walks fetch (F1..F3), decode (DEC) and a short execute tail per opcode.
// ctrl, state and halted depend only on registered state, so no input ever
// reaches them combinationally.
//
// The ALU function used in S_EX2 comes from exec_op_q. This register is
// captured at decode, so ctrl in S_EX2 does not look at the opcode input.
//
// A "retire" does three things on the same edge:
//   - returns to S_F1 (run=1) or S_IDLE (run=0); HALT goes to S_HALT instead,
//   - raises instr_done for the next cycle,
//   - bumps instr_cnt, which wraps to zero naturally.
// run is only looked at in S_IDLE and at retire.

module cpu_seq_ctrl #(
    parameter int              OP_W     = 8,
    parameter int              CNT_W    = 16,
    parameter logic [OP_W-1:0] OP_STORE = 8'h01,
    parameter logic [OP_W-1:0] OP_LOAD  = 8'h02,
    parameter logic [OP_W-1:0] OP_ADD   = 8'h03,
    parameter logic [OP_W-1:0] OP_SUB   = 8'h04,
    parameter logic [OP_W-1:0] OP_JGEZ  = 8'h05,
    parameter logic [OP_W-1:0] OP_JMP   = 8'h06,
    parameter logic [OP_W-1:0] OP_HALT  = 8'h07
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [OP_W-1:0]  opcode,
    input  logic             acc_sign,
    output logic [11:0]      ctrl,
    output logic [3:0]       state,
    output logic             halted,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_cnt
);

    // State encodings (fixed; visible on the state debug output)
    localparam logic [3:0] S_F1   = 4'd0;
    localparam logic [3:0] S_F2   = 4'd1;
    localparam logic [3:0] S_F3   = 4'd2;
    localparam logic [3:0] S_DEC  = 4'd3;
    localparam logic [3:0] S_ST1  = 4'd4;
    localparam logic [3:0] S_ST2  = 4'd5;
    localparam logic [3:0] S_RD   = 4'd6;
    localparam logic [3:0] S_EX1  = 4'd7;
    localparam logic [3:0] S_EX2  = 4'd8;
    localparam logic [3:0] S_JMP  = 4'd9;
    localparam logic [3:0] S_IDLE = 4'd14;
    localparam logic [3:0] S_HALT = 4'd15;

    // Control line positions
    localparam int C_PC_MAR   = 0;   // PC -> MAR
    localparam int C_MEM_RD   = 1;   // MEM -> MBR
    localparam int C_PC_INC   = 2;   // PC + 1
    localparam int C_MBR_BR   = 3;   // MBR -> BR
    localparam int C_IR_LD    = 4;   // MBR[15:8] -> IR
    localparam int C_ADR_MAR  = 5;   // MBR addr -> MAR
    localparam int C_ACC_MBR  = 6;   // ACC -> MBR
    localparam int C_MEM_WR   = 7;   // MBR -> MEM
    localparam int C_ALU_ADD  = 8;   // ALU add
    localparam int C_ALU_SUB  = 9;   // ALU sub
    localparam int C_ACC_LD   = 10;  // ALU result -> ACC (BR pass-through when no op)
    localparam int C_ADR_PC   = 11;  // MBR addr -> PC

    // ALU function latched at decode for the S_EX2 cycle
    localparam logic [1:0] EX_LOAD = 2'd0;
    localparam logic [1:0] EX_ADD  = 2'd1;
    localparam logic [1:0] EX_SUB  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       state_q, state_d;
    logic [1:0]       exec_op_q, exec_op_d;
    logic             instr_done_q, instr_done_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    logic             retire;
    logic             go_halt;

    // Next-state, retire detection and ALU-function capture
    always_comb begin
        state_d   = state_q;
        exec_op_d = exec_op_q;
        retire    = 1'b0;
        go_halt   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_F1;
                end
            end
            S_F1:  state_d = S_F2;
            S_F2:  state_d = S_F3;
            S_F3:  state_d = S_DEC;
            S_DEC: begin
                if (opcode == OP_STORE) begin
                    state_d = S_ST1;
                end else if (opcode == OP_LOAD) begin
                    state_d   = S_RD;
                    exec_op_d = EX_LOAD;
                end else if (opcode == OP_ADD) begin
                    state_d   = S_RD;
                    exec_op_d = EX_ADD;
                end else if (opcode == OP_SUB) begin
                    state_d   = S_RD;
                    exec_op_d = EX_SUB;
                end else if (opcode == OP_JMP) begin
                    state_d = S_JMP;
                end else if (opcode == OP_JGEZ) begin
                    // Non-negative ACC takes the jump; negative retires as a no-op
                    if (!acc_sign) begin
                        state_d = S_JMP;
                    end else begin
                        retire = 1'b1;
                    end
                end else if (opcode == OP_HALT) begin
                    retire  = 1'b1;
                    go_halt = 1'b1;
                end else begin
                    // Any unassigned opcode behaves as NOP
                    retire = 1'b1;
                end
            end
            S_ST1:  state_d = S_ST2;
            S_ST2:  retire  = 1'b1;
            S_RD:   state_d = S_EX1;
            S_EX1:  state_d = S_EX2;
            S_EX2:  retire  = 1'b1;
            S_JMP:  retire  = 1'b1;
            S_HALT: state_d = S_HALT;
            default: begin
                // Encodings 10..13 are unreachable; recover to idle
                state_d = S_IDLE;
            end
        endcase

        if (retire) begin
            if (go_halt) begin
                state_d = S_HALT;
            end else if (run) begin
                state_d = S_F1;
            end else begin
                state_d = S_IDLE;
            end
        end

        instr_done_d = retire;
        instr_cnt_d  = retire ? (instr_cnt_q + CNT_ONE) : instr_cnt_q;
    end

    // State and bookkeeping registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            exec_op_q    <= EX_LOAD;
            instr_done_q <= 1'b0;
            instr_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            exec_op_q    <= exec_op_d;
            instr_done_q <= instr_done_d;
            instr_cnt_q  <= instr_cnt_d;
        end
    end

    // Moore decode of control lines from the state register only
    always_comb begin
        ctrl = 12'd0;
        case (state_q)
            S_F1: ctrl[C_PC_MAR] = 1'b1;
            S_F2: begin
                ctrl[C_MEM_RD] = 1'b1;
                ctrl[C_PC_INC] = 1'b1;
            end
            S_F3:  ctrl[C_IR_LD]   = 1'b1;
            S_DEC: ctrl[C_ADR_MAR] = 1'b1;
            S_ST1: ctrl[C_ACC_MBR] = 1'b1;
            S_ST2: ctrl[C_MEM_WR]  = 1'b1;
            S_RD:  ctrl[C_MEM_RD]  = 1'b1;
            S_EX1: ctrl[C_MBR_BR]  = 1'b1;
            S_EX2: begin
                ctrl[C_ACC_LD]  = 1'b1;
                ctrl[C_ALU_ADD] = (exec_op_q == EX_ADD);
                ctrl[C_ALU_SUB] = (exec_op_q == EX_SUB);
            end
            S_JMP:   ctrl[C_ADR_PC] = 1'b1;
            default: ctrl = 12'd0;
        endcase
    end

    assign state      = state_q;
    assign halted     = (state_q == S_HALT);
    assign instr_done = instr_done_q;
    assign instr_cnt  = instr_cnt_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Testbench for cpu_seq_ctrl.
// Directed per-cycle vectors with hand-computed expectations are pushed into
// a queue. A monitor pops one entry on every falling edge and compares it.
module tb_cpu_seq_ctrl;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_STORE = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_SUB   = 8'h04;
    localparam logic [7:0] OP_JGEZ  = 8'h05;
    localparam logic [7:0] OP_HALT  = 8'h07;
    localparam logic [7:0] OP_BAD   = 8'hFF;

    localparam int W = 34;  // {state[4], ctrl[12], halted, done, cnt[16]}

    logic        clk;
    logic        rst;
    logic        run;
    logic [7:0]  opcode;
    logic        acc_sign;
    logic [11:0] ctrl;
    logic [3:0]  state;
    logic        halted;
    logic        instr_done;
    logic [15:0] instr_cnt;

    logic [W-1:0] exp_q[$];
    int vec_cnt  = 0;
    int err_cnt  = 0;
    int cyc      = 0;

    cpu_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .opcode     (opcode),
        .acc_sign   (acc_sign),
        .ctrl       (ctrl),
        .state      (state),
        .halted     (halted),
        .instr_done (instr_done),
        .instr_cnt  (instr_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: apply inputs for the next rising edge and queue the outputs
    // expected right after that edge.
    task automatic step(input logic r, input logic rn, input logic [7:0] op,
                        input logic sg, input logic [3:0] es,
                        input logic [11:0] ec, input logic eh,
                        input logic ed, input logic [15:0] ecnt);
        rst      = r;
        run      = rn;
        opcode   = op;
        acc_sign = sg;
        @(posedge clk);
        exp_q.push_back({es, ec, eh, ed, ecnt});
        @(negedge clk);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, ctrl, halted, instr_done, instr_cnt};
            vec_cnt++;
            if (a !== e) begin
                err_cnt++;
                $display("FAIL cycle%0d: state=%0d ctrl=%03h halted=%b done=%b cnt=%0d, required state=%0d ctrl=%03h halted=%b done=%b cnt=%0d",
                         cyc, a[33:30], a[29:18], a[17], a[16], a[15:0],
                         e[33:30], e[29:18], e[17], e[16], e[15:0]);
            end
        end
    end

    initial begin
        rst = 1'b0; run = 1'b0; opcode = 8'h00; acc_sign = 1'b0;

        // Reset hold, then idle with run=0
        for (int i = 0; i < 3; i++) step(0, 0, OP_NOP, 0, 14, 12'h000, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, OP_NOP, 0, 14, 12'h000, 0, 0, 0);

        // ADD: 7 cycles
        step(1, 1, OP_ADD, 0,  0, 12'h001, 0, 0, 0);
        step(1, 1, OP_ADD, 0,  1, 12'h006, 0, 0, 0);
        step(1, 1, OP_ADD, 0,  2, 12'h010, 0, 0, 0);
        step(1, 1, OP_ADD, 0,  3, 12'h020, 0, 0, 0);
        step(1, 1, OP_ADD, 0,  6, 12'h002, 0, 0, 0);
        step(1, 1, OP_ADD, 0,  7, 12'h008, 0, 0, 0);
        step(1, 1, OP_ADD, 0,  8, 12'h500, 0, 0, 0);
        step(1, 1, OP_JGEZ, 1, 0, 12'h001, 0, 1, 1);

        // JGEZ with negative ACC: retire straight from decode
        step(1, 1, OP_JGEZ, 1, 1, 12'h006, 0, 0, 1);
        step(1, 1, OP_JGEZ, 1, 2, 12'h010, 0, 0, 1);
        step(1, 1, OP_JGEZ, 1, 3, 12'h020, 0, 0, 1);
        step(1, 1, OP_JGEZ, 1, 0, 12'h001, 0, 1, 2);

        // JGEZ with non-negative ACC: taken through S_JMP
        step(1, 1, OP_JGEZ, 0, 1, 12'h006, 0, 0, 2);
        step(1, 1, OP_JGEZ, 0, 2, 12'h010, 0, 0, 2);
        step(1, 1, OP_JGEZ, 0, 3, 12'h020, 0, 0, 2);
        step(1, 1, OP_JGEZ, 0, 9, 12'h800, 0, 0, 2);
        step(1, 1, OP_JGEZ, 0, 0, 12'h001, 0, 1, 3);

        // Reset mid-fetch, then STORE (run dropped mid-instruction) then HALT
        step(0, 1, OP_STORE, 0, 14, 12'h000, 0, 0, 0);
        step(1, 1, OP_STORE, 0,  0, 12'h001, 0, 0, 0);
        step(1, 1, OP_STORE, 0,  1, 12'h006, 0, 0, 0);
        step(1, 1, OP_STORE, 0,  2, 12'h010, 0, 0, 0);
        step(1, 1, OP_STORE, 0,  3, 12'h020, 0, 0, 0);
        step(1, 0, OP_STORE, 0,  4, 12'h040, 0, 0, 0);
        step(1, 0, OP_STORE, 0,  5, 12'h080, 0, 0, 0);
        step(1, 1, OP_HALT,  0,  0, 12'h001, 0, 1, 1);
        step(1, 1, OP_HALT,  0,  1, 12'h006, 0, 0, 1);
        step(1, 1, OP_HALT,  0,  2, 12'h010, 0, 0, 1);
        step(1, 1, OP_HALT,  0,  3, 12'h020, 0, 0, 1);
        step(1, 1, OP_HALT,  0, 15, 12'h000, 1, 1, 2);
        for (int i = 0; i < 20; i++) step(1, i[0], OP_NOP, 0, 15, 12'h000, 1, 0, 2);

        // Reset out of HALT, then SUB aborted by reset during S_EX1
        step(0, 0, OP_SUB, 0, 14, 12'h000, 0, 0, 0);
        step(1, 1, OP_SUB, 0,  0, 12'h001, 0, 0, 0);
        step(1, 1, OP_SUB, 0,  1, 12'h006, 0, 0, 0);
        step(1, 1, OP_SUB, 0,  2, 12'h010, 0, 0, 0);
        step(1, 1, OP_SUB, 0,  3, 12'h020, 0, 0, 0);
        step(1, 1, OP_SUB, 0,  6, 12'h002, 0, 0, 0);
        step(1, 1, OP_SUB, 0,  7, 12'h008, 0, 0, 0);
        step(0, 1, OP_SUB, 0, 14, 12'h000, 0, 0, 0);
        step(1, 0, OP_SUB, 0, 14, 12'h000, 0, 0, 0);

        // Unknown opcode 0xFF as NOP, run dropped at retire -> idle
        step(1, 1, OP_BAD, 0,  0, 12'h001, 0, 0, 0);
        step(1, 1, OP_BAD, 0,  1, 12'h006, 0, 0, 0);
        step(1, 1, OP_BAD, 0,  2, 12'h010, 0, 0, 0);
        step(1, 1, OP_BAD, 0,  3, 12'h020, 0, 0, 0);
        step(1, 0, OP_BAD, 0, 14, 12'h000, 0, 1, 1);
        step(1, 0, OP_BAD, 0, 14, 12'h000, 0, 0, 1);
        step(1, 0, OP_BAD, 0, 14, 12'h000, 0, 0, 1);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            err_cnt++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
